fan_speed_ctrl: RTL and testbench
=================================

Name: fan_speed_ctrl

Overview:
- Consumes the debounced button pulses (short press and long-press repeat) and a power-off pulse. Maintains the fan speed level (0 = off, 1..3).
- Ramps the applied duty toward the per-level target, then drives a glitch-free PWM output to the motor driver.
- Sits directly downstream of the long-button debouncer. Feeds the motor PWM pin and the speed LEDs.

Parameters:
- PWM_PERIOD, 1000, clocks per PWM period (100 kHz at 100 MHz); must be ≥ 2 and ≤ 1023.
- DUTY_L1, 333, duty target in clocks for level 1.
- DUTY_L2, 666, duty target for level 2.
- DUTY_L3, 1000, duty target for level 3; all DUTY_Lx must be ≤ PWM_PERIOD.
- RAMP_DIV, 100_000, clocks between successive 1-unit duty steps during a ramp.

Ports:
- clk  input  1  system clock.
- reset_p  input  1  asynchronous, active-high reset.
- btn_pedge  input  1  short-press pulse (1 clk wide): step speed with wrap to off.
- held_pedge  input  1  long-press repeat pulse (1 clk wide): step speed without entering off.
- off_pulse  input  1  power-off pulse (1 clk wide).
- speed_level  output  2  current level 0..3.
- led  output  4  one-hot of speed_level (bit n set when level = n).
- duty_now  output  10  currently applied (ramped) duty.
- ramping  output  1  high while duty_now ≠ target.
- pwm_out  output  1  motor PWM.

Behaviour:
- Clock and reset: clk is the single clock domain. reset_p is asynchronous and active-high.
- Reset values:
  - speed_level = 0, led = 4'b0001, duty_now = 0, ramping = 0, pwm_out = 0.
  - PWM counter = 0, latched duty = 0, ramp divider = 0, FSM = IDLE.
- Level update (registered; speed_level changes the cycle after the pulse). Priority is off_pulse > btn_pedge > held_pedge.
  - off_pulse: level ← 0.
  - btn_pedge: level ← (level + 1) mod 4, i.e. 0→1→2→3→0.
  - held_pedge: level 0→1, 1→2, 2→3, 3→1. Holding never turns the fan off.
  - btn_pedge and held_pedge in the same cycle: one step, btn rule.
- Target: combinational from level: 0 → 0, 1 → DUTY_L1, 2 → DUTY_L2, 3 → DUTY_L3.
- Ramp FSM, states IDLE, RAMP_UP, RAMP_DOWN:
  - IDLE: if duty_now < target → RAMP_UP; if duty_now > target → RAMP_DOWN. Divider cleared on entry to either ramp state.
  - RAMP_UP / RAMP_DOWN: divider counts 0..RAMP_DIV-1. On terminal count, duty_now ±1 and divider restarts.
  - When duty_now = target → IDLE.
  - If the target changes direction mid-ramp, switch directly to the other ramp state and clear the divider.
- off_pulse override: duty_now ← 0 in the next cycle. FSM → IDLE, divider cleared. This is the immediate safety stop with no ramp-down.
- ramping = (duty_now ≠ target), registered alongside duty_now.
- PWM:
  - Counter runs 0..PWM_PERIOD-1 and wraps.
  - Latched duty ← duty_now only on the cycle the counter wraps to 0. A duty change never takes effect mid-period.
  - pwm_out registered = (counter < latched duty). Duty 0 gives constant 0; duty = PWM_PERIOD gives constant 1.
  - Exception for the off path: latched duty is also forced to 0 immediately. pwm_out is low from the cycle after off_pulse.
- Width rules: duty values are 10-bit unsigned. The ramp never overshoots the target or underflows below 0.
- Reset mid-ramp or mid-period: all state returns to reset values at once, asynchronously.

Test Plan:
Sim parameters: PWM_PERIOD=10, DUTY_L1=3, DUTY_L2=6, DUTY_L3=10, RAMP_DIV=2.
1. Short press cycling: 5 btn_pedge pulses spaced 50 clk → speed_level 1,2,3,0,1; led 0010,0100,1000,0001,0010.
2. Ramp: one btn_pedge from reset → ramping=1; duty_now steps 0→1→2→3, one step every 2 clk; then ramping=0, FSM IDLE. In the following PWM period pwm_out is high exactly 3 of 10 clocks.
3. Held wrap: level 3, held_pedge → level 1 (not 0). From level 0, held_pedge → 1. btn_pedge and held_pedge in the same cycle at level 2 → 3.
4. Off override: at level 3 mid-ramp (duty_now=7), off_pulse together with btn_pedge → next cycle level 0, duty_now 0, pwm_out 0 the cycle after. No further pulses appear.
5. Glitch-free update: change level while the counter = 4 → the current period's high time is unchanged. The new duty appears only from the next counter wrap.
6. Async reset: assert reset_p mid-ramp at level 2 between clock edges → all outputs are at reset values before the next clk edge. Normal operation resumes after release.

Source files
------------

// File: rtl/fan_speed_ctrl.sv
// Fan speed controller: speed level from button pulses, ramped duty, glitch-free PWM.
// Latency: level/off take effect 1 clk after the pulse; duty steps every RAMP_DIV clk.
// Backpressure: none. Every input pulse is acted on in the cycle it is sampled.
//
// Ports:
//   clk, reset_p            clock, asynchronous active-high reset
//   btn_pedge               short press: level 0->1->2->3->0
//   held_pedge              long-press repeat: level 0->1->2->3->1 (never turns off)
//   off_pulse               immediate stop: level 0, duty 0, PWM low
//   speed_level, led        current level and its one-hot form
//   duty_now, ramping       applied (ramped) duty, high while duty_now != target
//   pwm_out                 motor PWM, duty latched only at period start
module fan_speed_ctrl #(
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_L1    = 333,
  parameter int DUTY_L2    = 666,
  parameter int DUTY_L3    = 1000,
  parameter int RAMP_DIV   = 100_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       btn_pedge,
  input  logic       held_pedge,
  input  logic       off_pulse,
  output logic [1:0] speed_level,
  output logic [3:0] led,
  output logic [9:0] duty_now,
  output logic       ramping,
  output logic       pwm_out
);

  localparam int              DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [9:0]      CNT_LAST = 10'(PWM_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN} state_t;

  state_t           state_q, state_d;
  logic [1:0]       level_q, level_d;
  logic [9:0]       duty_q, duty_d;
  logic             ramping_q, ramping_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       cnt_q, cnt_d;
  logic [9:0]       lat_q, lat_d;
  logic             pwm_q, pwm_d;
  logic [9:0]       target_q, target_d;

  function automatic logic [9:0] target_of(input logic [1:0] lvl);
    case (lvl)
      2'd1:    target_of = 10'(DUTY_L1);
      2'd2:    target_of = 10'(DUTY_L2);
      2'd3:    target_of = 10'(DUTY_L3);
      default: target_of = 10'd0;
    endcase
  endfunction

  // Level stepping; off wins, and btn wins over held when both arrive together.
  always_comb begin
    level_d = level_q;
    if (off_pulse)       level_d = 2'd0;
    else if (btn_pedge)  level_d = level_q + 2'd1;
    else if (held_pedge) level_d = (level_q == 2'd3) ? 2'd1 : level_q + 2'd1;
  end

  assign target_q = target_of(level_q);
  assign target_d = target_of(level_d);

  // State register and all datapath registers.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q   <= IDLE;
      level_q   <= 2'd0;
      duty_q    <= 10'd0;
      ramping_q <= 1'b0;
      div_q     <= '0;
      cnt_q     <= 10'd0;
      lat_q     <= 10'd0;
      pwm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      duty_q    <= duty_d;
      ramping_q <= ramping_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      pwm_q     <= pwm_d;
    end
  end

  // Ramp FSM next state: direction follows the sign of (target - duty).
  always_comb begin
    state_d = state_q;
    if (off_pulse) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (duty_q < target_q)      state_d = RAMP_UP;
          else if (duty_q > target_q) state_d = RAMP_DOWN;
        end
        RAMP_UP: begin
          if (duty_q == target_q)     state_d = IDLE;
          else if (duty_q > target_q) state_d = RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (duty_q == target_q)     state_d = IDLE;
          else if (duty_q < target_q) state_d = RAMP_UP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Ramp FSM outputs: divider and duty step. A step is only taken while the
  // duty is still on the far side of the target, so it cannot overshoot.
  always_comb begin
    div_d  = '0;
    duty_d = duty_q;
    if (off_pulse) begin
      duty_d = 10'd0;
    end else if (state_d == state_q) begin
      if (state_q == RAMP_UP || state_q == RAMP_DOWN) begin
        if (div_q == DIV_LAST) begin
          duty_d = (state_q == RAMP_UP) ? duty_q + 10'd1 : duty_q - 10'd1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
    end
    ramping_d = (duty_d != target_d);
  end

  // PWM: duty is picked up only at the wrap so a period is never cut short
  // or stretched; off clears the latched duty at once as a safety stop.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? 10'd0 : cnt_q + 10'd1;
    lat_d = (cnt_q == CNT_LAST) ? duty_q : lat_q;
    if (off_pulse) lat_d = 10'd0;
    pwm_d = (cnt_d < lat_d);
  end

  assign speed_level = level_q;
  assign led         = 4'b0001 << level_q;
  assign duty_now    = duty_q;
  assign ramping     = ramping_q;
  assign pwm_out     = pwm_q;

endmodule

// File: tb/tb_fan_speed_ctrl.sv
module tb_fan_speed_ctrl;

  logic       clk;
  logic       reset_p;
  logic       btn_pedge;
  logic       held_pedge;
  logic       off_pulse;
  logic [1:0] speed_level;
  logic [3:0] led;
  logic [9:0] duty_now;
  logic       ramping;
  logic       pwm_out;

  fan_speed_ctrl #(
    .PWM_PERIOD(10), .DUTY_L1(3), .DUTY_L2(6), .DUTY_L3(10), .RAMP_DIV(2)
  ) dut (
    .clk(clk), .reset_p(reset_p), .btn_pedge(btn_pedge), .held_pedge(held_pedge),
    .off_pulse(off_pulse), .speed_level(speed_level), .led(led),
    .duty_now(duty_now), .ramping(ramping), .pwm_out(pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected snapshot at a given cycle; -1 marks a field as don't-care.
  typedef struct {
    int    cyc;
    string tag;
    int    lvl;
    int    duty;
    int    ramp;
    int    pwm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void push(int c, string tag, int l, int d, int r, int p);
    exp_t e;
    e.cyc = c; e.tag = tag; e.lvl = l; e.duty = d; e.ramp = r; e.pwm = p;
    q.push_back(e);
  endfunction

  function automatic void chk(string name, int c, int act, int exp);
    if (exp < 0) return;
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, c, act, exp);
    end
  endfunction

  // Monitor: samples outputs mid-cycle and retires every expectation due now.
  initial begin
    int led_tab [4];
    exp_t e;
    led_tab = '{1, 2, 4, 8};
    forever begin
      @(negedge clk);
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for cyc %0d missed (now %0d)", e.tag, e.cyc, cyc);
        end else begin
          chk({e.tag, ".level"},   cyc, int'(speed_level), e.lvl);
          chk({e.tag, ".led"},     cyc, int'(led), (e.lvl >= 0) ? led_tab[e.lvl] : -1);
          chk({e.tag, ".duty"},    cyc, int'(duty_now), e.duty);
          chk({e.tag, ".ramping"}, cyc, int'(ramping), e.ramp);
          chk({e.tag, ".pwm"},     cyc, int'(pwm_out), e.pwm);
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Ends on the negedge where reset is released; PWM counter is 0 in that cycle.
  task automatic do_reset(output int c0);
    @(negedge clk);
    reset_p = 1'b1;
    @(negedge clk);
    reset_p = 1'b0;
    c0 = cyc;
  endtask

  initial begin
    int c0, b, c1;
    int lvl_seq [5];
    int d_tab [8];
    int d, r, p, cnt, lat;

    reset_p = 1'b1; btn_pedge = 1'b0; held_pedge = 1'b0; off_pulse = 1'b0;

    // Reset state
    @(negedge clk);
    push(cyc, "reset", 0, 0, 0, 0);
    push(cyc + 1, "reset", 0, 0, 0, 0);
    wait_until(cyc + 2);

    // 1. Short press cycling
    do_reset(c0);
    lvl_seq = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      btn_pedge = 1'b1;
      push(cyc + 1, "short", lvl_seq[i], -1, -1, -1);
      @(negedge clk);
      btn_pedge = 1'b0;
      wait_until(cyc + 49);
    end

    // 2. Ramp 0 -> 3 and one PWM period with 3 high clocks
    do_reset(c0);
    btn_pedge = 1'b1;
    d_tab = '{0, 0, 0, 1, 1, 2, 2, 3};
    for (int k = 1; k <= 20; k++) begin
      d = (k <= 8) ? d_tab[k-1] : 3;
      r = (k < 8) ? 1 : 0;
      p = (k >= 10 && k <= 12) || (k == 20) ? 1 : 0;
      push(c0 + k, "ramp", 1, d, r, p);
    end
    @(negedge clk);
    btn_pedge = 1'b0;
    wait_until(c0 + 21);

    // 3. Held wrap and btn+held collision
    do_reset(c0);
    begin
      logic [1:0] bt [7];
      logic [1:0] ht [7];
      int         lt [7];
      bt = '{0, 1, 1, 0, 1, 1, 0};
      ht = '{1, 0, 0, 1, 0, 1, 1};
      lt = '{1, 2, 3, 1, 2, 3, 1};
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        btn_pedge  = bt[i][0];
        held_pedge = ht[i][0];
        push(cyc + 1, "held", lt[i], -1, -1, -1);
        @(negedge clk);
        btn_pedge  = 1'b0;
        held_pedge = 1'b0;
      end
    end

    // 4. Off override mid-ramp at duty 7, level 3, PWM currently high
    do_reset(c0);
    wait_until(c0 + 5);
    b = cyc;
    btn_pedge = 1'b1;
    push(b + 1, "off.setup", 1, -1, -1, -1);
    push(b + 2, "off.setup", 2, -1, -1, -1);
    push(b + 3, "off.setup", 3, -1, -1, -1);
    push(b + 16, "off.before", 3, 7, 1, 1);
    for (int k = 17; k <= 30; k++) push(b + k, "off.after", 0, 0, 0, 0);
    wait_until(b + 3);
    btn_pedge = 1'b0;
    wait_until(b + 16);
    off_pulse = 1'b1;
    btn_pedge = 1'b1;
    @(negedge clk);
    off_pulse = 1'b0;
    btn_pedge = 1'b0;
    wait_until(b + 31);

    // 5. Glitch-free duty update: level change while counter = 4
    do_reset(c0);
    btn_pedge = 1'b1;
    push(c0 + 1, "glitch.l1", 1, -1, -1, -1);
    for (int k = 10; k <= 39; k++) begin
      cnt = k % 10;
      lat = (k < 20) ? 3 : (k < 30) ? 4 : 6;
      d   = (k < 18) ? 3 : (k < 20) ? 4 : (k < 22) ? 5 : 6;
      r   = (k >= 15 && k < 22) ? 1 : 0;
      push(c0 + k, "glitch", (k < 15) ? 1 : 2, d, r, (cnt < lat) ? 1 : 0);
    end
    @(negedge clk);
    btn_pedge = 1'b0;
    wait_until(c0 + 14);
    btn_pedge = 1'b1;
    @(negedge clk);
    btn_pedge = 1'b0;
    wait_until(c0 + 40);

    // 6. Asynchronous reset mid-ramp at level 2, then resume
    do_reset(c0);
    btn_pedge = 1'b1;
    push(c0 + 1, "areset.setup", 1, -1, -1, -1);
    push(c0 + 2, "areset.setup", 2, -1, -1, -1);
    push(c0 + 6, "areset.before", 2, 2, 1, -1);
    push(c0 + 7, "areset.during", 0, 0, 0, 0);
    wait_until(c0 + 2);
    btn_pedge = 1'b0;
    wait_until(c0 + 6);
    @(posedge clk);
    #2;
    reset_p = 1'b1;
    wait_until(c0 + 8);
    reset_p = 1'b0;
    c1 = cyc;
    btn_pedge = 1'b1;
    push(c1 + 1, "areset.resume", 1, 0, 1, -1);
    push(c1 + 4, "areset.resume", 1, 1, 1, -1);
    push(c1 + 8, "areset.resume", 1, 3, 0, -1);
    @(negedge clk);
    btn_pedge = 1'b0;
    wait_until(c1 + 10);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations never retired, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
